// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and FIPS 180-4 helper functions for the
// iterative compression engine.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [7:0][31:0]  hash_t;   // index 0 = H0 / a
  typedef logic [15:0][31:0] block_t;  // index 0 = W0

  typedef struct packed {
    hash_t state;
  } ShaContext;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHUNK_WAIT,
    S_ROUNDS,
    S_ACCUM,
    S_DONE
  } CompressorState;

  localparam hash_t SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compressor_if.sv
// Context / chunk / digest handshake bundle between the chunk stage, the
// compressor and the digest consumer.
interface sha256_compressor_if;
  import sha256_pkg::*;

  logic      ctx_in_rdy;
  logic      ctx_in_vld;
  ShaContext ctx_in;
  logic      chunk_in_rdy;
  logic      chunk_in_vld;
  logic      chunk_in_last;
  block_t    chunk_in;
  logic      digest_out_rdy;
  logic      digest_out_vld;
  hash_t     digest_out;

  modport master (
    input  ctx_in_rdy, chunk_in_rdy, digest_out_vld, digest_out,
    output ctx_in_vld, ctx_in, chunk_in_vld, chunk_in_last, chunk_in,
           digest_out_rdy
  );

  modport slave (
    output ctx_in_rdy, chunk_in_rdy, digest_out_vld, digest_out,
    input  ctx_in_vld, ctx_in, chunk_in_vld, chunk_in_last, chunk_in,
           digest_out_rdy
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working vars a..h (index 0 = a) plus the
// schedule word and round constant in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t vars,
  input  word_t w,
  input  word_t k,
  output hash_t vars_nxt
);
  word_t t1, t2;

  always_comb begin
    t1 = vars[7] + big_sigma1(vars[4]) + ch(vars[4], vars[5], vars[6]) + k + w;
    t2 = big_sigma0(vars[0]) + maj(vars[0], vars[1], vars[2]);
    vars_nxt[0] = t1 + t2;
    vars_nxt[1] = vars[0];
    vars_nxt[2] = vars[1];
    vars_nxt[3] = vars[2];
    vars_nxt[4] = vars[3] + t1;
    vars_nxt[5] = vars[4];
    vars_nxt[6] = vars[5];
    vars_nxt[7] = vars[6];
  end
endmodule

// File: rtl/sha256_compressor.sv
// Iterative SHA-256 compressor: one round per cycle, 64 rounds plus one
// accumulate cycle per chunk, digest held on a valid/ready output.
module sha256_compressor
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sha256_compressor_if.slave bus
);
  CompressorState state, state_d;
  hash_t          h_q, v_q, v_nxt;
  block_t         w_q;
  word_t          w_new;
  logic [5:0]     rnd_q;
  logic           last_q;

  sha256_round u_round (
    .vars     (v_q),
    .w        (w_q[0]),
    .k        (K[rnd_q]),
    .vars_nxt (v_nxt)
  );

  assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    state_d            = state;
    bus.ctx_in_rdy     = 1'b0;
    bus.chunk_in_rdy   = 1'b0;
    bus.digest_out_vld = 1'b0;
    bus.digest_out     = '0;
    case (state)
      S_IDLE: begin
        bus.ctx_in_rdy = 1'b1;
        if (bus.ctx_in_vld) state_d = S_CHUNK_WAIT;
      end
      S_CHUNK_WAIT: begin
        bus.chunk_in_rdy = 1'b1;
        if (bus.chunk_in_vld) state_d = S_ROUNDS;
      end
      S_ROUNDS: if (rnd_q == 6'd63) state_d = S_ACCUM;
      S_ACCUM:  state_d = last_q ? S_DONE : S_CHUNK_WAIT;
      S_DONE: begin
        bus.digest_out_vld = 1'b1;
        bus.digest_out     = h_q;
        if (bus.digest_out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      w_q    <= '0;
      rnd_q  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.ctx_in_vld) h_q <= bus.ctx_in.state;
        S_CHUNK_WAIT:
          if (bus.chunk_in_vld) begin
            w_q    <= bus.chunk_in;
            v_q    <= h_q;
            last_q <= bus.chunk_in_last;
            rnd_q  <= '0;
          end
        S_ROUNDS: begin
          v_q   <= v_nxt;
          w_q   <= {w_new, w_q[15:1]};
          rnd_q <= rnd_q + 6'd1;
        end
        S_ACCUM:
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compressor.sv
// Scoreboard bench for sha256_compressor using FIPS 180-4 known-answer vectors.
module tb_sha256_compressor;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_compressor_if bus();
  sha256_compressor dut (.clk(clk), .rst(rst), .bus(bus));

  int    checks = 0;
  int    errors = 0;
  hash_t exp_q[$];

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_2A    = {
    256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
    256'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  // Big-endian word strings to index-0-first packed arrays.
  function automatic hash_t be8(logic [255:0] v);
    hash_t r;
    for (int i = 0; i < 8; i++) r[i] = v[255-32*i -: 32];
    return r;
  endfunction

  function automatic block_t be16(logic [511:0] v);
    block_t r;
    for (int i = 0; i < 16; i++) r[i] = v[511-32*i -: 32];
    return r;
  endfunction

  task automatic send_ctx(hash_t h);
    int n;
    n = 0;
    @(negedge clk);
    bus.ctx_in_vld   = 1'b1;
    bus.ctx_in.state = h;
    while (!bus.ctx_in_rdy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      errors++;
      $display("FAIL ctx_handshake: ctx_in_rdy=%b want 1 within 200 cycles", bus.ctx_in_rdy);
    end
    @(posedge clk); #1;
    bus.ctx_in_vld = 1'b0;
    bus.ctx_in     = '1;
  endtask

  task automatic send_chunk(logic [511:0] blk, logic last, logic push, logic [255:0] dig);
    int n;
    n = 0;
    @(negedge clk);
    bus.chunk_in_vld  = 1'b1;
    bus.chunk_in      = be16(blk);
    bus.chunk_in_last = last;
    while (!bus.chunk_in_rdy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      errors++;
      $display("FAIL chunk_handshake: chunk_in_rdy=%b want 1 within 200 cycles", bus.chunk_in_rdy);
    end
    @(posedge clk);
    if (push) exp_q.push_back(be8(dig));
    #1;
    bus.chunk_in_vld  = 1'b0;
    bus.chunk_in      = '1;
    bus.chunk_in_last = ~last;
  endtask

  // Returns cycles from the chunk handshake edge to the first cycle with
  // digest_out_vld high, or -1 on timeout.
  task automatic wait_vld(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.digest_out_vld) return;
      if (n >= 300) begin n = -1; return; end
    end
  endtask

  task automatic accept_digest();
    bus.digest_out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.digest_out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.ctx_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_ctx_rdy: got %b want 1", bus.ctx_in_rdy); end
    if (bus.chunk_in_rdy !== 1'b0) begin errors++; $display("FAIL reset_chunk_rdy: got %b want 0", bus.chunk_in_rdy); end
    if (bus.digest_out_vld !== 1'b0) begin errors++; $display("FAIL reset_digest_vld: got %b want 0", bus.digest_out_vld); end
    if (bus.digest_out !== '0) begin errors++; $display("FAIL reset_digest: got %h want 0", bus.digest_out); end
  endtask

  task automatic test_empty();
    int    n;
    hash_t want;
    send_ctx(SHA256_IV);
    @(negedge clk);
    checks++;
    if (bus.chunk_in_rdy !== 1'b1) begin errors++; $display("FAIL ctx_to_chunk_rdy: got %b want 1", bus.chunk_in_rdy); end
    send_chunk(BLK_EMPTY, 1'b1, 1'b1, D_EMPTY);
    wait_vld(n);
    checks++;
    if (n !== 66) begin errors++; $display("FAIL empty_latency: got %0d want 66", n); end
    want = exp_q.pop_front();
    checks++;
    if (bus.digest_out !== want) begin errors++; $display("FAIL empty_digest: got %h want %h", bus.digest_out, want); end
    accept_digest();
    @(negedge clk);
    checks += 2;
    if (bus.ctx_in_rdy !== 1'b1) begin errors++; $display("FAIL post_accept_ctx_rdy: got %b want 1", bus.ctx_in_rdy); end
    if (bus.digest_out_vld !== 1'b0) begin errors++; $display("FAIL post_accept_vld: got %b want 0", bus.digest_out_vld); end
  endtask

  task automatic test_abc_backpressure();
    int    n;
    hash_t want;
    send_ctx(SHA256_IV);
    send_chunk(BLK_ABC, 1'b1, 1'b1, D_ABC);
    // Junk on both input channels while rounds are running.
    repeat (20) begin
      @(negedge clk);
      bus.chunk_in_vld  = 1'b1;
      bus.chunk_in      = be16({16{$urandom()}});
      bus.chunk_in_last = 1'b0;
      bus.ctx_in_vld    = 1'b1;
      bus.ctx_in.state  = be8({8{$urandom()}});
    end
    checks++;
    if (bus.chunk_in_rdy !== 1'b0) begin errors++; $display("FAIL rounds_chunk_rdy: got %b want 0", bus.chunk_in_rdy); end
    @(negedge clk);
    bus.chunk_in_vld = 1'b0;
    bus.ctx_in_vld   = 1'b0;
    wait_vld(n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL abc_timeout: digest_out_vld=%b want 1", bus.digest_out_vld); end
    want = exp_q.pop_front();
    checks++;
    if (bus.digest_out !== want) begin errors++; $display("FAIL abc_digest: got %h want %h", bus.digest_out, want); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.digest_out_vld !== 1'b1 || bus.digest_out !== want) begin
        errors++;
        $display("FAIL abc_hold[%0d]: vld=%b digest=%h want vld=1 digest=%h", i, bus.digest_out_vld, bus.digest_out, want);
      end
    end
    accept_digest();
  endtask

  task automatic test_two_chunk();
    int    n, low;
    hash_t want;
    send_ctx(SHA256_IV);
    send_chunk(BLK_2A, 1'b0, 1'b0, '0);
    low = 0;
    forever begin
      @(negedge clk);
      if (bus.chunk_in_rdy || low >= 200) break;
      low++;
    end
    checks++;
    if (low !== 65) begin errors++; $display("FAIL two_chunk_rdy_low: got %0d cycles want 65", low); end
    send_chunk(BLK_2B, 1'b1, 1'b1, D_TWO);
    wait_vld(n);
    checks++;
    if (n !== 66) begin errors++; $display("FAIL two_chunk_latency: got %0d want 66", n); end
    want = exp_q.pop_front();
    checks++;
    if (bus.digest_out !== want) begin errors++; $display("FAIL two_chunk_digest: got %h want %h", bus.digest_out, want); end
    accept_digest();
  endtask

  task automatic test_reset_mid();
    int    n;
    hash_t want;
    send_ctx(SHA256_IV);
    send_chunk(BLK_ABC, 1'b1, 1'b0, '0);
    repeat (31) @(negedge clk);  // now in the cycle executing round 30
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.ctx_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset_ctx_rdy: got %b want 1", bus.ctx_in_rdy); end
    if (bus.digest_out_vld !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b want 0", bus.digest_out_vld); end
    if (bus.chunk_in_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_chunk_rdy: got %b want 0", bus.chunk_in_rdy); end
    send_ctx(SHA256_IV);
    send_chunk(BLK_ABC, 1'b1, 1'b1, D_ABC);
    wait_vld(n);
    checks++;
    if (n !== 66) begin errors++; $display("FAIL rerun_latency: got %0d want 66", n); end
    want = exp_q.pop_front();
    checks++;
    if (bus.digest_out !== want) begin errors++; $display("FAIL rerun_digest: got %h want %h", bus.digest_out, want); end
    accept_digest();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    bus.ctx_in_vld     = 1'b0;
    bus.ctx_in         = '0;
    bus.chunk_in_vld   = 1'b0;
    bus.chunk_in_last  = 1'b0;
    bus.chunk_in       = '0;
    bus.digest_out_rdy = 1'b0;
    test_reset();
    test_empty();
    test_abc_backpressure();
    test_two_chunk();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sha256_compressor.md
# sha256_compressor

Iterative SHA-256 compression engine sitting directly downstream of the chunk stage. It accepts an initial hash context, then consumes padded 512-bit chunks one at a time. Each chunk takes 64 single-cycle rounds plus one accumulate cycle. After the chunk flagged last, it presents the 256-bit digest on a valid/ready output.

## Interface
- No parameters. Round constants, IV and widths come from `sha256_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ctx_in_rdy` out 1: engine can accept a context.
- `ctx_in_vld` in 1: context valid.
- `ctx_in` in `sha256_pkg::ShaContext`: only `.state` is used, as H0..H7 (`[7:0][31:0]`, index 0 = H0).
- `chunk_in_rdy` out 1: engine can accept a chunk.
- `chunk_in_vld` in 1: chunk valid.
- `chunk_in_last` in 1: qualifies the chunk as the final one of the message. Sampled with `chunk_in`.
- `chunk_in` in `[15:0][31:0]`: padded block, index 0 = W0, big-endian words.
- `digest_out_rdy` in 1: consumer accepts the digest.
- `digest_out_vld` out 1: digest valid.
- `digest_out` out `[7:0][31:0]`: final H0..H7.

## Operation
- FSM states:
  - IDLE: `ctx_in_rdy`=1. On `ctx_in_vld`, latch `ctx_in.state` into H[7:0] and go to CHUNK_WAIT.
  - CHUNK_WAIT: `chunk_in_rdy`=1. On `chunk_in_vld`:
    - load the W[15:0] window with `chunk_in`;
    - load working vars a..h from H;
    - latch `last`;
    - clear the round counter `rnd` (6 bits);
    - go to ROUNDS.
  - ROUNDS: one round per cycle using W[0] and K[rnd].
    - Window shifts down by one each round; new W[15] = σ1(W[14]) + W[9] + σ0(W[1]) + W[0], mod 2^32.
    - On `rnd`==63, go to ACCUM.
  - ACCUM: H[i] <= H[i] + var[i], mod 2^32. Go to DONE if `last`, else CHUNK_WAIT.
  - DONE: `digest_out_vld`=1 and `digest_out`=H. On `digest_out_rdy`, go to IDLE.
- Ready/valid outputs are decodes of the registered state; no combinational path from any input to any output.
- All additions are modulo 2^32, with carries discarded.
- Σ0/Σ1/σ0/σ1, Ch and Maj follow FIPS 180-4 exactly.
- Handshake boundary conditions:
  - `chunk_in_vld` is ignored outside CHUNK_WAIT.
  - `ctx_in_vld` is ignored outside IDLE.
  - Inputs need not be held after the handshake cycle.
- While in DONE, `digest_out` is stable for however long `digest_out_rdy` stays low.
- `rst` is synchronous: it takes effect at the next edge from any state, including mid-ROUNDS, and forces IDLE. Partial state is discarded.
- Reset values:
  - `ctx_in_rdy`: 1, since IDLE decodes to 1, effective the cycle after the reset edge.
  - `chunk_in_rdy`: 0.
  - `digest_out_vld`: 0.
  - `digest_out`: 0.
  - H, W, a..h, `rnd`, `last`: 0.

## Timing
- Context accepted at edge T0 → `chunk_in_rdy`=1 from cycle T0+1.
- Chunk accepted at edge T → round 0 executes in cycle T+1 and round 63 in T+64. ACCUM is in T+65.
- After ACCUM:
  - not last: `chunk_in_rdy` is high again from T+66, i.e. 66-cycle chunk-to-chunk throughput;
  - last: `digest_out_vld` is high from T+66.
- Digest accepted at edge D → `ctx_in_rdy`=1 from D+1.
- Latency from the handshake of the last chunk to the digest: 66 cycles with no backpressure.

## Structure
- `sha256_pkg` holds:
  - `K[0:63]` constant array;
  - `SHA256_IV` (`[7:0][31:0]`);
  - the `ShaContext` typedef (existing);
  - the `CompressorState` enum;
  - the σ/Σ/Ch/Maj functions, as automatic functions.
- One combinational sub-module, `sha256_round`:
  - inputs: a..h, W, K;
  - outputs: next a..h.
- The top level holds the FSM, the round counter, the W window and the H/working registers.

## Test plan
- Empty message:
  - stimulus: ctx with `SHA256_IV`, then one last chunk with W0=80000000 and W1..W15=0;
  - required digest: e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with `digest_out_vld` asserted 66 cycles after the chunk handshake.
- "abc":
  - stimulus: IV, then W0=61626380, W1..W14=0, W15=00000018, last;
  - required digest: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-chunk message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - stimulus: the first chunk with `last`=0, then the second chunk with `last`=1;
  - required digest: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1;
  - `chunk_in_rdy` must be low for exactly 65 cycles between the two chunks.
- Backpressure and ignored inputs:
  - hold `digest_out_rdy`=0 for 20 cycles on the "abc" case → `digest_out_vld` stays 1 and `digest_out` is unchanged;
  - drive `chunk_in_vld`=1 during ROUNDS → no effect on the result.
- Reset mid-operation:
  - assert `rst` for one cycle at round 30 of "abc" → `ctx_in_rdy`=1 and `digest_out_vld`=0 the next cycle;
  - a subsequent full "abc" run produces the correct digest.
